// File: rtl/vx_context_copy_engine_if.sv
// Bundle of request, drain, register read and register write signals for the
// context copy engine. The engine sits on the slave modport.
interface vx_context_copy_engine_if #(
  parameter int NT = 4,
  parameter int NW = 8
);
  localparam int WW = $clog2(NW);
  localparam int TW = (WW > NT) ? WW : NT;

  logic          req_valid;
  logic          req_ready;
  logic          req_is_wspawn;
  logic [WW-1:0] req_src_warp;
  logic [TW-1:0] req_target;
  logic          pipe_drained;
  logic          rd_en;
  logic [WW-1:0] rd_warp;
  logic [4:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          wr_en;
  logic [WW-1:0] wr_warp;
  logic [NT-1:0] wr_lane_mask;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          out_copy_stall;
  logic          done;

  modport master (
    output req_valid, req_is_wspawn, req_src_warp, req_target, pipe_drained, rd_data,
    input  req_ready, rd_en, rd_warp, rd_addr, wr_en, wr_warp, wr_lane_mask,
           wr_addr, wr_data, out_copy_stall, done
  );

  modport slave (
    input  req_valid, req_is_wspawn, req_src_warp, req_target, pipe_drained, rd_data,
    output req_ready, rd_en, rd_warp, rd_addr, wr_en, wr_warp, wr_lane_mask,
           wr_addr, wr_data, out_copy_stall, done
  );
endinterface

// File: rtl/vx_context_copy_engine.sv
// Copies lane-0 registers to a spawned warp (wspawn) or to sibling lanes (clone).
// Define VX_COPY_SKIP_X0_EN to skip register x0 (copy x1..x31 only).
module vx_context_copy_engine #(
  parameter int NT = 4,
  parameter int NW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_context_copy_engine_if.slave  bus,
  output logic [1:0]               dbg_state_o
);
  localparam int WW = $clog2(NW);
  localparam logic [NT-1:0] LANE0 = {{(NT-1){1'b0}}, 1'b1};
`ifdef VX_COPY_SKIP_X0_EN
  localparam logic [4:0] FIRST = 5'd1;
`else
  localparam logic [4:0] FIRST = 5'd0;
`endif

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so requests never overlap.
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, COPY = 2'd2, FLUSH = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [4:0]    addr_q, addr_d;
  logic [WW-1:0] src_q, dst_q;
  logic [NT-1:0] mask_q;
  logic          wr_en_q;
  logic [4:0]    wr_addr_q;
  logic          accept;

  assign accept = bus.req_valid && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRAIN;
          addr_d  = FIRST;
        end
      end
      DRAIN: if (bus.pipe_drained) state_d = COPY;
      COPY: begin
        addr_d = addr_q + 5'd1;
        if (addr_q == 5'd31) state_d = FLUSH;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Destination warp and lane mask are resolved once at accept time.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      mask_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      addr_q    <= addr_d;
      wr_en_q   <= (state_q == COPY);
      wr_addr_q <= addr_q;
      if (accept) begin
        src_q  <= bus.req_src_warp;
        dst_q  <= bus.req_is_wspawn ? bus.req_target[WW-1:0] : bus.req_src_warp;
        mask_q <= bus.req_is_wspawn ? LANE0 : (bus.req_target[NT-1:0] & ~LANE0);
      end
    end
  end

  always_comb begin
    bus.req_ready      = (state_q == IDLE);
    bus.rd_en          = (state_q == COPY);
    bus.done           = (state_q == FLUSH);
    bus.out_copy_stall = (bus.req_valid && (state_q == IDLE)) || (state_q != IDLE);
    bus.rd_warp        = src_q;
    bus.rd_addr        = addr_q;
    bus.wr_en          = wr_en_q;
    bus.wr_warp        = dst_q;
    bus.wr_lane_mask   = mask_q;
    bus.wr_addr        = wr_addr_q;
    // Read data returns one cycle after rd_en, aligned with the registered write.
    bus.wr_data        = wr_en_q ? bus.rd_data : 32'd0;
    dbg_state_o        = state_q;
  end
endmodule

// File: tb/tb_vx_context_copy_engine.sv
// Self-checking bench for vx_context_copy_engine: register-file responder,
// per-cycle monitor with an expected-write queue, directed and random requests.
module tb_vx_context_copy_engine;
  localparam int NT = 4;
  localparam int NW = 8;
  localparam int WW = $clog2(NW);
  localparam int TW = (WW > NT) ? WW : NT;
  localparam int EW = WW + NT + 5 + 32;
`ifdef VX_COPY_SKIP_X0_EN
  localparam int FIRST = 1;
  localparam int N     = 31;
`else
  localparam int FIRST = 0;
  localparam int N     = 32;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  vx_context_copy_engine_if #(.NT(NT), .NW(NW)) bus ();

  vx_context_copy_engine #(.NT(NT), .NW(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rf [NW][32];
  always @(posedge clk) bus.rd_data <= rf[bus.rd_warp][bus.rd_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  bit            busy = 1'b0;
  int            acc_cyc = 0;
  int            acc_delay = 0;
  int            cur_delay = 0;
  logic [WW-1:0] acc_src;
  int            last_done = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      int rel;
      bit exp_rd, exp_wr, exp_dn;
      rel    = cyc - acc_cyc - acc_delay;
      exp_rd = busy && rel >= 2 && rel < 2 + N;
      exp_wr = busy && rel >= 3 && rel <= 2 + N;
      exp_dn = busy && rel == 2 + N;
      check_val("rd_en", bus.rd_en, exp_rd);
      check_val("wr_en", bus.wr_en, exp_wr);
      check_val("done", bus.done, exp_dn);
      check_val("req_ready", bus.req_ready, !busy);
      check_val("stall", bus.out_copy_stall, busy || bus.req_valid);
      if (bus.rd_en && exp_rd) begin
        check_val("rd_addr", bus.rd_addr, FIRST + rel - 2);
        check_val("rd_warp", bus.rd_warp, acc_src);
      end
      if (bus.wr_en) begin
        if (exp_q.size() == 0) check_val("wr_extra", 1'b1, 1'b0);
        else check_val("wr_beat", {bus.wr_warp, bus.wr_lane_mask, bus.wr_addr, bus.wr_data},
                       exp_q.pop_front());
      end
      if (exp_dn) begin
        busy = 1'b0;
        last_done = cyc;
        check_val("wr_left", exp_q.size(), 0);
      end
      if (reset) begin
        busy = 1'b0;
        exp_q.delete();
      end
      if (bus.req_valid && bus.req_ready && !reset) begin
        logic [WW-1:0] dst;
        logic [NT-1:0] msk;
        dst = bus.req_is_wspawn ? bus.req_target[WW-1:0] : bus.req_src_warp;
        msk = bus.req_is_wspawn ? 4'b0001 : {bus.req_target[NT-1:1], 1'b0};
        busy      = 1'b1;
        acc_cyc   = cyc;
        acc_delay = cur_delay;
        acc_src   = bus.req_src_warp;
        for (int a = FIRST; a < 32; a++)
          exp_q.push_back({dst, msk, a[4:0], rf[bus.req_src_warp][a]});
      end
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check_val("done_timeout", 1'b0, 1'b1);
    #1;
  endtask

  task automatic send(input logic ws, input logic [WW-1:0] src, input logic [TW-1:0] tgt,
                      input int delay, input bit wait_end);
    bit got = 1'b0;
    @(posedge clk); #1;
    bus.req_valid     = 1'b1;
    bus.req_is_wspawn = ws;
    bus.req_src_warp  = src;
    bus.req_target    = tgt;
    bus.pipe_drained  = (delay == 0);
    cur_delay         = delay;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
    end
    if (!got) check_val("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (delay) begin @(posedge clk); #1; end
    bus.pipe_drained = 1'b1;
    if (wait_end) wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int d1;
    for (int w = 0; w < NW; w++)
      for (int a = 0; a < 32; a++) rf[w][a] = $urandom;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_is_wspawn = 1'b0;
    bus.req_src_warp = '0;
    bus.req_target = '0;
    bus.pipe_drained = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_val("rst_ready", bus.req_ready, 1'b1);
    check_val("rst_rd_en", bus.rd_en, 1'b0);
    check_val("rst_wr_en", bus.wr_en, 1'b0);
    check_val("rst_done", bus.done, 1'b0);
    check_val("rst_stall", bus.out_copy_stall, 1'b0);
    check_val("rst_mask", bus.wr_lane_mask, 4'b0000);
    check_val("rst_wdata", bus.wr_data, 32'd0);
    check_val("rst_state", dbg_state, 2'd0);
    mon_en = 1'b1;

    // wspawn warp 2 -> warp 5
    send(1'b1, 3'd2, 4'd5, 0, 1'b1);
    check_val("ws_done_lat", last_done - acc_cyc, 2 + N);

    // clone, full mask: lane 0 excluded
    send(1'b0, 3'd3, 4'b1111, 0, 1'b1);
    check_val("cl_done_lat", last_done - acc_cyc, 2 + N);

    // drain held off for 7 cycles
    send(1'b1, 3'd1, 4'd6, 7, 1'b1);
    check_val("drain_done_lat", last_done - acc_cyc, 2 + N + 7);

    // reset on the 10th COPY cycle
    send(1'b0, 3'd4, 4'b1010, 0, 1'b0);
    while (cyc < acc_cyc + 11) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("mid_rst_rd_en", bus.rd_en, 1'b0);
    check_val("mid_rst_wr_en", bus.wr_en, 1'b0);
    check_val("mid_rst_done", bus.done, 1'b0);
    check_val("mid_rst_ready", bus.req_ready, 1'b1);
    repeat (6) @(negedge clk);

    // back-to-back with req_valid held high
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_is_wspawn = 1'b1;
    bus.req_src_warp = 3'd0;
    bus.req_target = 4'd7;
    bus.pipe_drained = 1'b1;
    cur_delay = 0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_is_wspawn = 1'b0;
    bus.req_src_warp = 3'd6;
    bus.req_target = 4'b0110;
    wait_done();
    d1 = last_done;
    @(negedge clk); #1;
    check_val("b2b_accept", acc_cyc, d1 + 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_done();
    check_val("b2b_done_lat", last_done - acc_cyc, 2 + N);

    // clone with only lane 0 requested: zero effective mask
    send(1'b0, 3'd7, 4'b0001, 0, 1'b1);
    check_val("zero_mask_done_lat", last_done - acc_cyc, 2 + N);

    for (int k = 0; k < 4; k++)
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, NW - 1)),
           4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b1);

    repeat (5) @(negedge clk);
    check_val("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
